// File: rtl/keyed_lut_pkg.sv
// Shared types for the keyed lookup table: entry layout, index type, zero data word.
package keyed_lut_pkg;

  localparam int unsigned NrKeyDef   = 4;
  localparam int unsigned KeyLenDef  = 7;
  localparam int unsigned DataLenDef = 32;
  localparam int unsigned IdxLenDef  = $clog2(NrKeyDef);

  typedef logic [KeyLenDef-1:0]  key_t;
  typedef logic [DataLenDef-1:0] data_t;
  typedef logic [IdxLenDef-1:0]  idx_t;

  typedef struct packed {
    logic  valid;
    key_t  key;
    data_t data;
  } entry_t;

  localparam data_t ZeroData = '0;

endpackage

// File: rtl/keyed_lut_prio_enc.sv
// Lowest-index-first priority encoder over the per-entry hit vector.
module keyed_lut_prio_enc #(
  parameter int unsigned  NR_KEY  = 4,
  localparam int unsigned IDX_LEN = $clog2(NR_KEY)
) (
  input  logic [NR_KEY-1:0]  hit_i,
  output logic               any_hit_o,
  output logic [IDX_LEN-1:0] idx_o,
  output logic               multi_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (hit_i[i]) idx_o = IDX_LEN'(i);
    end
  end

  assign any_hit_o = |hit_i;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_o   = |(hit_i & (hit_i - NR_KEY'(1)));

endmodule

// File: rtl/keyed_lut_table.sv
// Runtime-programmable key->data lookup table with a registered valid/ready response.
// Optional build macro KEYED_LUT_MULTIHIT_EN adds rsp_multi_o (>=2 valid entries matched).
module keyed_lut_table
  import keyed_lut_pkg::*;
#(
  parameter int unsigned  NR_KEY      = NrKeyDef,
  parameter int unsigned  KEY_LEN     = KeyLenDef,
  parameter int unsigned  DATA_LEN    = DataLenDef,
  parameter int unsigned  HAS_DEFAULT = 0,
  localparam int unsigned IDX_LEN     = $clog2(NR_KEY)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [IDX_LEN-1:0]  wr_idx_i,
  input  logic [KEY_LEN-1:0]  wr_key_i,
  input  logic [DATA_LEN-1:0] wr_data_i,
  input  logic                wr_valid_i,
  input  logic                flush_i,
  input  logic [DATA_LEN-1:0] default_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [KEY_LEN-1:0]  req_key_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_LEN-1:0] rsp_data_o,
  output logic                rsp_hit_o,
  output logic [IDX_LEN-1:0]  rsp_idx_o
`ifdef KEYED_LUT_MULTIHIT_EN
  ,
  output logic                rsp_multi_o
`endif
);

  // Entry layout comes from the package, so the widths must track it.
  if (NR_KEY != NrKeyDef || KEY_LEN != KeyLenDef || DATA_LEN != DataLenDef) begin : g_cfg_check
    $error("keyed_lut_table widths must match keyed_lut_pkg");
  end

  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];

  entry_t wr_entry;
  logic   wr_fire;

  assign wr_entry = '{valid: wr_valid_i, key: wr_key_i, data: wr_data_i};
  assign wr_fire  = wr_en_i && (32'(wr_idx_i) < NR_KEY);

  // Next valid bits: flush clears all, a same-cycle write overrides its own entry.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) valid_d = '0;
    if (wr_fire) valid_d[wr_idx_i] = wr_entry.valid;
  end

  // Valid bits are the only table state that needs reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // Key/data payload storage, deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      key_q[wr_idx_i]  <= wr_entry.key;
      data_q[wr_idx_i] <= wr_entry.data;
    end
  end

  logic [NR_KEY-1:0] hit_vec;
  logic              any_hit;
  idx_t              hit_idx;
  logic              hit_multi;

  // Compare against registered contents, so same-cycle writes are not yet visible.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      hit_vec[i] = valid_q[i] && (key_q[i] == req_key_i);
    end
  end

  keyed_lut_prio_enc #(
    .NR_KEY (NR_KEY)
  ) u_prio_enc (
    .hit_i     (hit_vec),
    .any_hit_o (any_hit),
    .idx_o     (hit_idx),
    .multi_o   (hit_multi)
  );

  data_t lookup_data;
  logic  req_fire;

  assign lookup_data = any_hit ? data_q[hit_idx] :
                       ((HAS_DEFAULT != 0) ? default_i : ZeroData);
  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign req_fire    = req_valid_i && req_ready_o;

  logic  rsp_valid_q;
  data_t rsp_data_q;
  logic  rsp_hit_q;
  idx_t  rsp_idx_q;

  // Single response register: load on accept, drop valid on a handshake with no refill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= lookup_data;
      rsp_hit_q   <= any_hit;
      rsp_idx_q   <= any_hit ? hit_idx : '0;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_idx_o   = rsp_idx_q;

`ifdef KEYED_LUT_MULTIHIT_EN
  logic rsp_multi_q;

  // Multi-hit flag travels with the response it describes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       rsp_multi_q <= 1'b0;
    else if (req_fire) rsp_multi_q <= hit_multi;
  end

  assign rsp_multi_o = rsp_multi_q;
`else
  logic unused_multi;
  assign unused_multi = hit_multi;
`endif

endmodule

// File: doc/keyed_lut_table.md
Name: keyed_lut_table

Overview:
- Programmable key→data lookup table: NR_KEY entries, each holding a valid bit, a key and a data word.
- Entries are written and invalidated at runtime through a write port.
- Lookups use a valid/ready request and response handshake, with a registered response carrying data, a hit flag and the matching index.
- Sits beside decode/CSR logic wherever a runtime-reconfigurable key→value map is needed (e.g. opcode remap, address-window select).

Parameters:
- NR_KEY, 4, number of table entries (≥2)
- KEY_LEN, 7, key width in bits
- DATA_LEN, 32, data width in bits
- HAS_DEFAULT, 0, 1 = on miss return default_i; 0 = on miss return all-zero data
- IDX_LEN, $clog2(NR_KEY), entry index width (derived, not overridden)

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- wr_en_i  input  1  write entry wr_idx_i this cycle
- wr_idx_i  input  IDX_LEN  entry index to write/invalidate
- wr_key_i  input  KEY_LEN  key to store
- wr_data_i  input  DATA_LEN  data to store
- wr_valid_i  input  1  valid bit to store (0 = invalidate entry)
- flush_i  input  1  invalidate all entries
- default_i  input  DATA_LEN  miss data (used only when HAS_DEFAULT=1)
- req_valid_i  input  1  lookup request valid
- req_ready_o  output  1  lookup request accepted when high with req_valid_i
- req_key_i  input  KEY_LEN  lookup key
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  consumer accepts response
- rsp_data_o  output  DATA_LEN  looked-up data
- rsp_hit_o  output  1  key matched a valid entry
- rsp_idx_o  output  IDX_LEN  index of matching entry (0 on miss)

Behaviour:
- Reset (async, rst_ni=0):
  - all entry valid bits = 0; key/data storage is not reset.
  - rsp_valid_o=0, rsp_data_o=0, rsp_hit_o=0, rsp_idx_o=0.
- req_ready_o = !rsp_valid_o || rsp_ready_i (combinational; single output register, no skid buffer).
- Request accepted on clock edge with req_valid_i && req_ready_o. The response registers load the result and rsp_valid_o=1 the next cycle, giving latency 1.
- Response held stable until rsp_valid_o && rsp_ready_i.
  - If no new request is accepted that cycle, rsp_valid_o clears.
  - If a new request is accepted the same cycle, the response registers load the new result back-to-back. Throughput is 1 lookup/cycle.
- Match: entry i hits iff valid[i] && key[i]==req_key_i. On multiple hits, the lowest index wins: its data and index are returned. Results are never OR-merged.
- Miss: rsp_hit_o=0, rsp_idx_o=0, rsp_data_o = HAS_DEFAULT ? default_i (sampled at acceptance) : 0.
- Write: on edge with wr_en_i, entry wr_idx_i ← {wr_valid_i, wr_key_i, wr_data_i}. wr_idx_i ≥ NR_KEY is ignored.
- Flush: on edge with flush_i, all valid bits clear. If wr_en_i is high the same cycle, the write takes priority for its entry.
- Ordering: a lookup accepted in the same cycle as a write/flush sees the pre-write contents. Changes are visible to requests accepted on the following cycle.
- A response already held in the output register is not altered by later writes or flushes.

Optional Feature:
- Macro: KEYED_LUT_MULTIHIT_EN.
- With the macro defined:
  - extra output rsp_multi_o (1 bit), registered with the response, set when ≥2 valid entries matched; reset 0.
  - a write that would create a duplicate valid key is still performed. No blocking occurs.
- Without the macro: the port and its logic are absent.

Decomposition:
- Package keyed_lut_pkg:
  - entry struct typedef (valid, key, data).
  - index typedef.
  - localparam for zero data.
- One sub-module: keyed_lut_prio_enc. Input is the NR_KEY-bit hit vector. Outputs are any_hit, the lowest set index and a multi-hit flag. It is purely combinational and instantiated once.

Test Plan:
- Reset, then lookup key 0x13 → rsp_valid_o 1 cycle after acceptance, rsp_hit_o=0, rsp_data_o=0 (HAS_DEFAULT=0). With HAS_DEFAULT=1 and default_i=0xDEAD, rsp_data_o=0xDEAD.
- Write idx2={1,0x13,0xCAFE0001}, lookup 0x13 next cycle → hit=1, idx=2, data=0xCAFE0001.
- Write idx1 and idx3 both key 0x05 (data 0x11/0x33), lookup 0x05 → data=0x11, idx=1. With KEYED_LUT_MULTIHIT_EN, rsp_multi_o=1.
- Backpressure: hold rsp_ready_i=0 for 3 cycles with req_valid_i high → req_ready_o=0, response stable. Raise rsp_ready_i → next result follows with no bubble.
- Same-cycle write idx0 key 0x2A and lookup 0x2A → miss. Repeat lookup next cycle → hit, idx=0. Then flush_i → a lookup after flush misses.
- Assert rst_ni=0 mid-stream while rsp_valid_o=1 → rsp_valid_o drops immediately (async). After release, previously written keys miss.
